// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the external-memory arbiter.
//   mem_cmd_t   - 65-bit command word {rnw, word address, length in words}
//   route_t     - read-return routing entry {requester port, words expected}
//   arb_state_t - command/write-data FSM states
package mem_arb_pkg;

    localparam int unsigned CMD_WIDTH = 65;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned PORT_W    = 3;

    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] len;
    } mem_cmd_t;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [31:0]       len;
    } route_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WDATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_route_fifo.sv
// mem_arb_route_fifo: FIFO of outstanding read routes, in issue order.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, push_data : enqueue a route (ignored when full unless popping)
//   pop             : dequeue the head (ignored when empty)
//   head            : current head entry (valid while !empty)
//   full, empty     : occupancy flags
// A pop and a push in the same cycle are both honoured, even when full.
module mem_arb_route_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned depth = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  route_t push_data,
    input  logic   pop,
    output route_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(depth);

    route_t         slots [depth];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = slots[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external-memory port between num_ports requesters.
//   clk, reset_n                       : memory-domain clock, async active-low reset
//   req_cmd_valid/ready/data           : per-requester command channel (mem_cmd_t)
//   req_wr_valid/ready/data            : per-requester write-data channel
//   req_rd_valid/ready, req_rd_data    : per-requester read return (data broadcast)
//   mem_cmd_*, mem_wr_*, mem_rd_*      : memory adapter side
//   grant_id                           : last granted requester
//   busy                               : command/write in progress or reads outstanding
// Round-robin command grant, write burst owned by the grantee, reads routed
// back in command order through a route FIFO.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned num_ports       = 4,
    parameter int unsigned mem_width       = 32,
    parameter int unsigned max_outstanding = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [num_ports-1:0]           req_cmd_valid,
    output logic [num_ports-1:0]           req_cmd_ready,
    input  logic [num_ports*CMD_WIDTH-1:0] req_cmd_data,
    input  logic [num_ports-1:0]           req_wr_valid,
    output logic [num_ports-1:0]           req_wr_ready,
    input  logic [num_ports*mem_width-1:0] req_wr_data,
    output logic [num_ports-1:0]           req_rd_valid,
    input  logic [num_ports-1:0]           req_rd_ready,
    output logic [mem_width-1:0]           req_rd_data,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic [CMD_WIDTH-1:0]           mem_cmd_data,
    output logic                           mem_wr_valid,
    input  logic                           mem_wr_ready,
    output logic [mem_width-1:0]           mem_wr_data,
    input  logic                           mem_rd_valid,
    output logic                           mem_rd_ready,
    input  logic [mem_width-1:0]           mem_rd_data,
    output logic [$clog2(num_ports)-1:0]   grant_id,
    output logic                           busy
);

    localparam int unsigned GW = $clog2(num_ports);
    localparam int unsigned CW = GW + 1;

    arb_state_t           state, state_next;
    mem_cmd_t             cmd_q;
    logic [31:0]          wr_count;
    logic [31:0]          rd_remaining;
    logic [31:0]          rd_len_eff;

    mem_cmd_t             cmds     [num_ports];
    logic [mem_width-1:0] wr_words [num_ports];
    logic [num_ports-1:0] eligible;
    logic                 found;
    logic [GW-1:0]        pick;
    logic [CW-1:0]        cand;

    logic                 load_cmd, load_wr, dec_wr;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                 rd_xfer;
    route_t               push_route, head;

    always_comb begin
        for (int unsigned i = 0; i < num_ports; i++) begin
            cmds[i]     = req_cmd_data[i*CMD_WIDTH +: CMD_WIDTH];
            wr_words[i] = req_wr_data[i*mem_width +: mem_width];
        end
    end

    // Round-robin search starting one past the last grant.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int unsigned i = 0; i < num_ports; i++)
            eligible[i] = req_cmd_valid[i] & ~(cmds[i].rnw & fifo_full);
        for (int unsigned k = 1; k <= num_ports; k++) begin
            cand = {1'b0, grant_id} + CW'(k);
            if (cand >= CW'(num_ports)) cand = cand - CW'(num_ports);
            if (!found && eligible[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state;
        load_cmd      = 1'b0;
        load_wr       = 1'b0;
        dec_wr        = 1'b0;
        fifo_push     = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_data  = '0;
        req_cmd_ready = '0;
        mem_wr_valid  = 1'b0;
        mem_wr_data   = '0;
        req_wr_ready  = '0;
        push_route.port = PORT_W'(grant_id);
        push_route.len  = cmd_q.len;
        case (state)
            IDLE: begin
                if (found) begin
                    load_cmd   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_cmd_valid           = 1'b1;
                mem_cmd_data            = cmd_q;
                req_cmd_ready[grant_id] = mem_cmd_ready;
                if (mem_cmd_ready) begin
                    if (cmd_q.len == 32'd0) begin
                        state_next = IDLE;
                    end else if (cmd_q.rnw) begin
                        fifo_push  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load_wr    = 1'b1;
                        state_next = WDATA;
                    end
                end
            end
            WDATA: begin
                mem_wr_valid           = req_wr_valid[grant_id];
                mem_wr_data            = wr_words[grant_id];
                req_wr_ready[grant_id] = mem_wr_ready;
                if (req_wr_valid[grant_id] && mem_wr_ready) begin
                    dec_wr = 1'b1;
                    if (wr_count == 32'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // rd_remaining is zero until the head's first word moves, so the head's
    // own length stands in for the count of a freshly reached entry.
    always_comb begin
        rd_len_eff   = (rd_remaining == 32'd0) ? head.len : rd_remaining;
        req_rd_valid = '0;
        req_rd_data  = '0;
        mem_rd_ready = 1'b0;
        rd_xfer      = 1'b0;
        fifo_pop     = 1'b0;
        if (!fifo_empty) begin
            for (int unsigned i = 0; i < num_ports; i++) begin
                if (head.port == PORT_W'(i)) begin
                    req_rd_valid[i] = mem_rd_valid;
                    mem_rd_ready    = req_rd_ready[i];
                end
            end
            req_rd_data = mem_rd_data;
            rd_xfer     = mem_rd_valid & mem_rd_ready;
            fifo_pop    = rd_xfer & (rd_len_eff == 32'd1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant_id     <= '0;
            cmd_q        <= '0;
            wr_count     <= '0;
            rd_remaining <= '0;
        end else begin
            state <= state_next;
            if (load_cmd) begin
                grant_id <= pick;
                cmd_q    <= cmds[pick];
            end
            if (load_wr)     wr_count <= cmd_q.len;
            else if (dec_wr) wr_count <= wr_count - 32'd1;
            if (rd_xfer)     rd_remaining <= fifo_pop ? 32'd0 : rd_len_eff - 32'd1;
        end
    end

    mem_arb_route_fifo #(
        .depth(max_outstanding)
    ) u_route_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_route),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy = (state != IDLE) | ~fifo_empty | (rd_remaining != 32'd0);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int MO = 4;

    logic              clk;
    logic              reset_n;
    logic [NP-1:0]     req_cmd_valid, req_cmd_ready;
    logic [NP*65-1:0]  req_cmd_data;
    logic [NP-1:0]     req_wr_valid, req_wr_ready;
    logic [NP*W-1:0]   req_wr_data;
    logic [NP-1:0]     req_rd_valid, req_rd_ready;
    logic [W-1:0]      req_rd_data;
    logic              mem_cmd_valid, mem_cmd_ready;
    logic [64:0]       mem_cmd_data;
    logic              mem_wr_valid, mem_wr_ready;
    logic [W-1:0]      mem_wr_data;
    logic              mem_rd_valid, mem_rd_ready;
    logic [W-1:0]      mem_rd_data;
    logic [1:0]        grant_id;
    logic              busy;

    mem_arbiter #(
        .num_ports(NP),
        .mem_width(W),
        .max_outstanding(MO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready), .req_cmd_data(req_cmd_data),
        .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready), .req_wr_data(req_wr_data),
        .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready), .req_rd_data(req_rd_data),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_data(mem_cmd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] valid; logic [1:0] grant; } arb_vec_t;
    typedef struct { int port; logic [31:0] data; } rd_rec_t;

    int          n_checks;
    int          n_fail;
    int          cmd_acc [NP];
    int          wr_sent [NP];
    int          mem_cmd_cnt, mem_wr_cnt, mem_rd_cnt;
    int          bad_wr_ready, bad_rd;
    logic [1:0]  grant_log [$];
    logic [64:0] cmd_log   [$];
    logic [31:0] wr_log    [$];
    rd_rec_t     rd_log    [$];
    logic [31:0] rd_word;
    arb_vec_t    vecs [10];

    function automatic logic [64:0] mk(logic rnw, logic [31:0] addr, logic [31:0] len);
        return {rnw, addr, len};
    endfunction

    function automatic logic [31:0] wr_word(int p, int n);
        return 32'hA000_0000 | (32'(p) << 16) | 32'(n);
    endfunction

    task automatic check(string name, logic [64:0] act, logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cmd(int p, logic [64:0] c);
        req_cmd_data[p*65 +: 65] = c;
    endtask

    task automatic reset_wr_src();
        for (int p = 0; p < NP; p++) begin
            wr_sent[p] = 0;
            req_wr_data[p*W +: W] = wr_word(p, 0);
        end
    endtask

    task automatic clear_logs();
        mem_cmd_cnt = 0; mem_wr_cnt = 0; mem_rd_cnt = 0;
        bad_wr_ready = 0;
        grant_log.delete(); cmd_log.delete(); wr_log.delete(); rd_log.delete();
    endtask

    // Called at a falling edge: samples what will transfer at the next rising
    // edge, then at the following falling edge reacts as the requesters and
    // memory would (drop accepted commands, advance write/read data).
    task automatic tick();
        logic [NP-1:0] acc_mask, wr_mask;
        logic          rd_x;
        #1;
        if (mem_cmd_valid && mem_cmd_ready) begin
            mem_cmd_cnt++;
            cmd_log.push_back(mem_cmd_data);
            grant_log.push_back(grant_id);
        end
        if (mem_wr_valid && mem_wr_ready) begin
            mem_wr_cnt++;
            wr_log.push_back(mem_wr_data);
        end
        rd_x = mem_rd_valid && mem_rd_ready;
        if (rd_x) mem_rd_cnt++;
        if ((req_wr_ready & ~(4'b0001 << grant_id)) != 4'b0) bad_wr_ready++;
        if (!$onehot0(req_rd_valid)) bad_rd++;
        for (int p = 0; p < NP; p++)
            if (req_rd_valid[p] && req_rd_ready[p]) rd_log.push_back('{p, req_rd_data});
        acc_mask = req_cmd_valid & req_cmd_ready;
        wr_mask  = req_wr_valid & req_wr_ready;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (acc_mask[p]) begin
                cmd_acc[p]++;
                req_cmd_valid[p] = 1'b0;
            end
            if (wr_mask[p]) begin
                wr_sent[p]++;
                req_wr_data[p*W +: W] = wr_word(p, wr_sent[p]);
            end
        end
        if (rd_x) begin
            rd_word++;
            mem_rd_data = rd_word;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, n0;
        n_checks = 0; n_fail = 0; bad_rd = 0;
        for (int p = 0; p < NP; p++) cmd_acc[p] = 0;
        reset_n = 1'b0;
        req_cmd_valid = '0; req_cmd_data = '0;
        req_wr_valid = '0; req_rd_ready = 4'hF;
        mem_cmd_ready = 1'b1; mem_wr_ready = 1'b1;
        mem_rd_valid = 1'b0; rd_word = 32'hD000_0000; mem_rd_data = rd_word;
        reset_wr_src();
        clear_logs();

        vecs[0] = '{4'b1111, 2'd1}; vecs[1] = '{4'b1111, 2'd2};
        vecs[2] = '{4'b1111, 2'd3}; vecs[3] = '{4'b1111, 2'd0};
        vecs[4] = '{4'b0001, 2'd0}; vecs[5] = '{4'b1001, 2'd3};
        vecs[6] = '{4'b0011, 2'd0}; vecs[7] = '{4'b0110, 2'd1};
        vecs[8] = '{4'b0101, 2'd2}; vecs[9] = '{4'b0001, 2'd0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state, and read side idle with an empty route FIFO.
        mem_rd_valid = 1'b1;
        #1;
        check("rst_cmd_valid", mem_cmd_valid, 0);
        check("rst_wr_valid", mem_wr_valid, 0);
        check("rst_req_ready", {req_cmd_ready, req_wr_ready}, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("empty_rd_route", {mem_rd_ready, req_rd_valid}, 0);
        mem_rd_valid = 1'b0;
        @(negedge clk);

        // Round-robin table with zero-length writes.
        for (int v = 0; v < 10; v++) begin
            for (int p = 0; p < NP; p++) set_cmd(p, mk(1'b0, 32'h1000 + p, 32'd0));
            clear_logs();
            req_cmd_valid = vecs[v].valid;
            for (int k = 0; k < 6 && mem_cmd_cnt == 0; k++) tick();
            req_cmd_valid = '0;
            check($sformatf("arb_grant_%0d", v), grant_id, vecs[v].grant);
            check($sformatf("arb_cmd_cnt_%0d", v), mem_cmd_cnt, 1);
            if (cmd_log.size() > 0)
                check($sformatf("arb_cmd_data_%0d", v), cmd_log[0],
                      mk(1'b0, 32'h1000 + 32'(vecs[v].grant), 32'd0));
            tick();
        end

        // Four simultaneous len=2 writes: grants 1,2,3,0 with their bursts.
        reset_wr_src();
        clear_logs();
        for (int p = 0; p < NP; p++) set_cmd(p, mk(1'b0, 32'h10 * p, 32'd2));
        req_wr_valid = 4'hF;
        req_cmd_valid = 4'hF;
        for (int k = 0; k < 40 && !(mem_cmd_cnt == 4 && !busy); k++) tick();
        req_wr_valid = '0;
        check("t1_cmd_cnt", mem_cmd_cnt, 4);
        check("t1_wr_cnt", mem_wr_cnt, 8);
        if (grant_log.size() == 4) begin
            check("t1_grant0", grant_log[0], 1);
            check("t1_grant1", grant_log[1], 2);
            check("t1_grant2", grant_log[2], 3);
            check("t1_grant3", grant_log[3], 0);
        end
        if (wr_log.size() == 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("t1_wr_%0d", i), wr_log[i], wr_word((i / 2 + 1) % 4, i % 2));
        check("t1_other_wr_ready", bad_wr_ready, 0);

        // Reads from port 2 (len 3) then port 0 (len 2), returned in order.
        clear_logs();
        set_cmd(2, mk(1'b1, 32'h100, 32'd3));
        req_cmd_valid[2] = 1'b1;
        for (int k = 0; k < 8 && req_cmd_valid[2]; k++) tick();
        set_cmd(0, mk(1'b1, 32'h200, 32'd2));
        req_cmd_valid[0] = 1'b1;
        for (int k = 0; k < 8 && req_cmd_valid[0]; k++) tick();
        check("t2_busy_outstanding", busy, 1);
        rd_word = 32'hD000_0000; mem_rd_data = rd_word;
        mem_rd_valid = 1'b1;
        for (int k = 0; k < 20 && mem_rd_cnt < 5; k++) tick();
        mem_rd_valid = 1'b0;
        check("t2_rd_cnt", rd_log.size(), 5);
        if (rd_log.size() == 5)
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t2_rd_port_%0d", i), rd_log[i].port, (i < 3) ? 2 : 0);
                check($sformatf("t2_rd_data_%0d", i), rd_log[i].data, 32'hD000_0000 + 32'(i));
            end
        #1;
        check("t2_busy_done", busy, 0);
        @(negedge clk);

        // Route FIFO full: fifth read held back while a write is granted.
        clear_logs();
        for (int p = 0; p < NP; p++) begin
            set_cmd(p, mk(1'b1, 32'h300 + p, 32'd1));
            req_cmd_valid[p] = 1'b1;
            for (int k = 0; k < 8 && req_cmd_valid[p]; k++) tick();
        end
        check("t3_fill_cmds", mem_cmd_cnt, 4);
        acc0 = cmd_acc[0];
        set_cmd(0, mk(1'b1, 32'h400, 32'd1));
        set_cmd(1, mk(1'b0, 32'h500, 32'd1));
        reset_wr_src();
        req_wr_valid[1] = 1'b1;
        req_cmd_valid[0] = 1'b1;
        req_cmd_valid[1] = 1'b1;
        for (int k = 0; k < 8 && req_cmd_valid[1]; k++) tick();
        check("t3_write_grant", grant_id, 1);
        repeat (6) tick();
        req_wr_valid = '0;
        check("t3_read_blocked", cmd_acc[0], acc0);
        check("t3_write_words", mem_wr_cnt, 1);
        n0 = mem_rd_cnt;
        mem_rd_valid = 1'b1;
        for (int k = 0; k < 8 && mem_rd_cnt == n0; k++) tick();
        mem_rd_valid = 1'b0;
        for (int k = 0; k < 8 && req_cmd_valid[0]; k++) tick();
        check("t3_read_issued", cmd_acc[0], acc0 + 1);
        mem_rd_valid = 1'b1;
        for (int k = 0; k < 20 && busy; k++) tick();
        mem_rd_valid = 1'b0;
        check("t3_rd_cnt", mem_rd_cnt, 5);
        if (rd_log.size() == 5) begin
            check("t3_rd_port0", rd_log[0].port, 0);
            check("t3_rd_port3", rd_log[3].port, 3);
            check("t3_rd_port4", rd_log[4].port, 0);
        end
        check("t3_busy_done", busy, 0);

        // Zero-length write from port 3.
        clear_logs();
        set_cmd(3, mk(1'b0, 32'h600, 32'd0));
        req_cmd_valid[3] = 1'b1;
        for (int k = 0; k < 6 && mem_cmd_cnt == 0; k++) tick();
        check("t4_grant", grant_id, 3);
        check("t4_idle_after", busy, 0);
        repeat (2) tick();
        check("t4_cmd_cnt", mem_cmd_cnt, 1);
        check("t4_no_wr", mem_wr_cnt, 0);

        // len=4 write with mem_wr_ready toggling every cycle.
        clear_logs();
        reset_wr_src();
        req_wr_valid = 4'hF;
        set_cmd(2, mk(1'b0, 32'h700, 32'd4));
        req_cmd_valid[2] = 1'b1;
        mem_wr_ready = 1'b1;
        for (int k = 0; k < 40 && !(mem_cmd_cnt > 0 && !busy); k++) begin
            tick();
            mem_wr_ready = ~mem_wr_ready;
        end
        mem_wr_ready = 1'b1;
        req_wr_valid = '0;
        check("t5_grant", grant_id, 2);
        check("t5_wr_cnt", mem_wr_cnt, 4);
        check("t5_port2_sent", wr_sent[2], 4);
        check("t5_others_sent", wr_sent[0] + wr_sent[1] + wr_sent[3], 0);
        check("t5_other_wr_ready", bad_wr_ready, 0);
        if (wr_log.size() == 4) check("t5_last_word", wr_log[3], wr_word(2, 3));

        // Asynchronous reset in the middle of a write burst.
        clear_logs();
        reset_wr_src();
        set_cmd(3, mk(1'b0, 32'h800, 32'd4));
        req_wr_valid = 4'b1000;
        req_cmd_valid[3] = 1'b1;
        for (int k = 0; k < 10 && mem_wr_cnt < 2; k++) tick();
        check("t6_grant", grant_id, 3);
        check("t6_mid_burst", mem_wr_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_outputs", {mem_cmd_valid, mem_wr_valid, mem_rd_ready, req_cmd_ready,
                                   req_wr_ready, req_rd_valid, grant_id, busy, mem_wr_data}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        req_wr_valid = '0;
        for (int p = 0; p < NP; p++) set_cmd(p, mk(1'b0, 32'h900 + p, 32'd0));
        clear_logs();
        req_cmd_valid = 4'hF;
        for (int k = 0; k < 6 && mem_cmd_cnt == 0; k++) tick();
        req_cmd_valid = '0;
        check("t6_first_grant", grant_id, 1);
        if (cmd_log.size() > 0) check("t6_first_cmd", cmd_log[0], mk(1'b0, 32'h901, 32'd0));
        repeat (2) tick();
        check("t6_idle", busy, 0);

        check("rd_valid_onehot", bad_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
